serial_shifter_32_bit: RTL and testbench
========================================

Name: serial_shifter_32_bit

Overview:
Multi-cycle, area-optimised counterpart of the single-cycle 32-bit barrel shifter in the arithmetic library. It accepts one shift request through a start/ready handshake and iterates one bit position per clock. It returns the result with a one-cycle Done pulse. It serves the RV32I shift instructions (SLL/SRL/SRA), plus rotate-right, in low-area MCU builds where the execute stage stalls on Ready.

Parameters:
ResetResult, 32'h00000000, value loaded into Result on reset.

Ports:
Clock  input  1  system clock; all state updates on rising edge
nReset  input  1  synchronous, active-low reset
Start  input  1  request valid; accepted only when Ready=1
Op  input  2  00 SLL, 01 SRL, 11 SRA, 10 ROR
DataA  input  32  operand, sampled on accept
ShiftAmount  input  5  shift distance 0..31, sampled on accept
Flush  input  1  abort the in-flight operation
Ready  output  1  block can accept a request (states IDLE, DONE)
Done  output  1  single-cycle pulse; Result valid
Result  output  32  shifted value; held until the next accept

Behaviour:
- One clock domain. Reset is synchronous and active-low: when nReset=0 at a rising Clock edge, state goes to IDLE, Ready=1, Done=0, Result=ResetResult, counter=0. Reset mid-operation discards the operation with no Done.
- States:
  - IDLE, transition on Start: go to BUSY.
  - BUSY, while counter!=0: stay in BUSY.
  - BUSY, when counter==0: go to DONE.
  - DONE, on Start: go to BUSY.
  - DONE, otherwise: go to IDLE.
- Accept (Ready & Start at edge E0): working reg <= DataA, counter <= ShiftAmount, op register <= Op. State goes to BUSY.
- BUSY, counter!=0: working reg shifts 1 position per edge, and counter decrements.
  - SLL: shift-in 0 at bit 0.
  - SRL: shift-in 0 at bit 31.
  - SRA: shift-in the current bit 31.
  - ROR: shift-in the current bit 0 at bit 31.
- BUSY, counter==0: Result <= working reg, Done=1 for exactly that cycle, state goes to DONE.
- Latency: Done is high in the cycle after edge E(N+1), with N = ShiftAmount. N=0 gives 1 cycle; N=31 gives 32 cycles.
- Ready=1 in IDLE and DONE. This allows back-to-back accept in the DONE cycle, giving throughput of one op per N+2 cycles.
- Start while BUSY is ignored and produces no side effects. The operands are not captured.
- Flush=1 at an edge in BUSY: go to IDLE, no Done, Result unchanged.
  - Flush in IDLE or DONE: no effect on Result. Done still deasserts normally.
  - Flush and Start in the same edge: Flush wins and the request is not accepted.
- Result changes only on the BUSY-to-DONE transition or on reset.
- Operand inputs may change freely after accept.

Optional Feature:
- Macro: SERIAL_SHIFTER_RADIX4_EN
- Defined: in BUSY, when counter>=4, shift 4 positions per edge and subtract 4. Otherwise shift 1 position. Latency becomes floor(N/4)+(N mod 4)+1; N=31 gives 11 cycles. Shift-in rules are identical: SRA replicates bit 31 ×4, ROR moves bits [3:0] to [31:28].
- Undefined: 1 position per cycle only, with no 4-step logic present.

Decomposition:
- Shared package shifter_pkg holds:
  - Op encodings: OP_SLL=2'b00, OP_SRL=2'b01, OP_ROR=2'b10, OP_SRA=2'b11.
  - State encoding: ST_IDLE, ST_BUSY, ST_DONE.
  - Width constant SHIFT_W=32.
- One natural sub-module: shift_step, a combinational single-step shifter. It takes the value, op and a step-size select (1 or 4, the latter only under the macro) and returns the next value.

Test Plan:
- SLL, DataA=0x00000001, ShiftAmount=5, Start one cycle -> Done pulses 6 cycles after accept with Result=0x00000020. With radix-4 enabled, Done pulses after 3 cycles.
- SRA, DataA=0x80000000, ShiftAmount=31 -> Result=0xFFFFFFFF after 32 cycles (11 with radix-4). SRL with the same operands -> 0x00000001.
- SRL, DataA=0x80000000, ShiftAmount=0 -> Done 1 cycle after accept, Result=0x80000000. Then ROR 0x00000001 by 1, issued in the DONE cycle -> accepted back-to-back, Result=0x80000000.
- Start during BUSY with DataA=0xDEADBEEF -> ignored, and the original op completes unchanged.
- Flush in the 3rd BUSY cycle of SLL 0x1 by 10 -> IDLE next cycle, no Done, Result still holds the previous value. A new request then completes correctly.
- nReset low for one edge mid-operation -> next cycle Ready=1, Done=0, Result=0x00000000, and no Done pulse appears later.

Source files
------------

// File: rtl/shifter_pkg.sv
// Shared types for the serial 32-bit shifter.
// Op and state encodings plus datapath width.
package shifter_pkg;

    localparam int SHIFT_W = 32;

    typedef enum logic [1:0] {
        OP_SLL = 2'b00,
        OP_SRL = 2'b01,
        OP_ROR = 2'b10,
        OP_SRA = 2'b11
    } op_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_BUSY = 2'b01,
        ST_DONE = 2'b10
    } state_t;

endpackage

// File: rtl/shift_step.sv
// Combinational one-step shifter (1 bit, or 4 bits
// when SERIAL_SHIFTER_RADIX4_EN is defined).
module shift_step
    import shifter_pkg::*;
(
    input  logic [SHIFT_W-1:0] value_i,
    input  op_t                op_i,
`ifdef SERIAL_SHIFTER_RADIX4_EN
    input  logic               step4_i,
`endif
    output logic [SHIFT_W-1:0] next_o
);

    logic [SHIFT_W-1:0] one_d;

    always_comb begin
        one_d = value_i;
        case (op_i)
            OP_SLL: one_d = {value_i[30:0], 1'b0};
            OP_SRL: one_d = {1'b0, value_i[31:1]};
            OP_SRA: one_d = {value_i[31], value_i[31:1]};
            OP_ROR: one_d = {value_i[0], value_i[31:1]};
            default: one_d = value_i;
        endcase
    end

`ifdef SERIAL_SHIFTER_RADIX4_EN
    logic [SHIFT_W-1:0] four_d;

    always_comb begin
        four_d = value_i;
        case (op_i)
            OP_SLL: four_d = {value_i[27:0], 4'b0000};
            OP_SRL: four_d = {4'b0000, value_i[31:4]};
            OP_SRA: four_d = {{4{value_i[31]}}, value_i[31:4]};
            OP_ROR: four_d = {value_i[3:0], value_i[31:4]};
            default: four_d = value_i;
        endcase
    end

    assign next_o = step4_i ? four_d : one_d;
`else
    assign next_o = one_d;
`endif

endmodule

// File: rtl/serial_shifter_32_bit.sv
// Multi-cycle SLL/SRL/SRA/ROR shifter, one step per clock.
// Define SERIAL_SHIFTER_RADIX4_EN for 4-bit steps.
module serial_shifter_32_bit
    import shifter_pkg::*;
#(
    parameter logic [SHIFT_W-1:0] ResetResult = 32'h00000000
) (
    input  logic               Clock,
    input  logic               nReset,
    input  logic               Start,
    input  logic [1:0]         Op,
    input  logic [SHIFT_W-1:0] DataA,
    input  logic [4:0]         ShiftAmount,
    input  logic               Flush,
    output logic               Ready,
    output logic               Done,
    output logic [SHIFT_W-1:0] Result
);

    state_t             state_q, state_d;
    logic [SHIFT_W-1:0] work_q, work_d;
    logic [SHIFT_W-1:0] result_q, result_d;
    logic [4:0]         cnt_q, cnt_d;
    op_t                op_q, op_d;
    logic [SHIFT_W-1:0] step_val;
    logic [4:0]         step_amt;

`ifdef SERIAL_SHIFTER_RADIX4_EN
    logic step4;
    assign step4    = (cnt_q >= 5'd4);
    assign step_amt = step4 ? 5'd4 : 5'd1;
`else
    assign step_amt = 5'd1;
`endif

    shift_step u_step (
        .value_i (work_q),
        .op_i    (op_q),
`ifdef SERIAL_SHIFTER_RADIX4_EN
        .step4_i (step4),
`endif
        .next_o  (step_val)
    );

    always_comb begin
        state_d  = state_q;
        work_d   = work_q;
        result_d = result_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                state_d = ST_IDLE;
                if (!Flush && Start) begin
                    state_d = ST_BUSY;
                    work_d  = DataA;
                    cnt_d   = ShiftAmount;
                    op_d    = op_t'(Op);
                end
            end
            ST_BUSY: begin
                if (Flush) begin
                    state_d = ST_IDLE;
                end else if (cnt_q != 5'd0) begin
                    work_d = step_val;
                    cnt_d  = cnt_q - step_amt;
                end else begin
                    result_d = work_q;
                    state_d  = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (!nReset) begin
            state_q  <= ST_IDLE;
            work_q   <= '0;
            result_q <= ResetResult;
            cnt_q    <= 5'd0;
            op_q     <= OP_SLL;
        end else begin
            state_q  <= state_d;
            work_q   <= work_d;
            result_q <= result_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
        end
    end

    assign Ready  = (state_q == ST_IDLE) || (state_q == ST_DONE);
    assign Done   = (state_q == ST_DONE);
    assign Result = result_q;

endmodule

// File: tb/tb_serial_shifter_32_bit.sv
// Directed self-checking bench for serial_shifter_32_bit.
module tb_serial_shifter_32_bit;

    logic        Clock = 1'b0;
    logic        nReset;
    logic        Start;
    logic [1:0]  Op;
    logic [31:0] DataA;
    logic [4:0]  ShiftAmount;
    logic        Flush;
    logic        Ready;
    logic        Done;
    logic [31:0] Result;

    int checks = 0;
    int errors = 0;

    localparam logic [1:0] SLL = 2'b00;
    localparam logic [1:0] SRL = 2'b01;
    localparam logic [1:0] ROR = 2'b10;
    localparam logic [1:0] SRA = 2'b11;

    serial_shifter_32_bit dut (
        .Clock       (Clock),
        .nReset      (nReset),
        .Start       (Start),
        .Op          (Op),
        .DataA       (DataA),
        .ShiftAmount (ShiftAmount),
        .Flush       (Flush),
        .Ready       (Ready),
        .Done        (Done),
        .Result      (Result)
    );

    always #5 Clock = ~Clock;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [4:0]  amt;
        logic [31:0] res;
    } vec_t;

    vec_t vecs[12];

    function automatic int exp_lat(input logic [4:0] n);
`ifdef SERIAL_SHIFTER_RADIX4_EN
        return int'(n) / 4 + int'(n) % 4 + 1;
`else
        return int'(n) + 1;
`endif
    endfunction

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Drive a request in the current cycle and return after the accept edge.
    task automatic accept(input logic [1:0] op, input logic [31:0] a,
                          input logic [4:0] amt);
        Start = 1'b1;
        Op = op;
        DataA = a;
        ShiftAmount = amt;
        @(posedge Clock);
        #1;
        Start = 1'b0;
        DataA = $urandom;
        ShiftAmount = 5'($urandom);
        Op = 2'($urandom);
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge Clock);
            #1;
            lat++;
            if (Done) break;
        end
        if (!Done) lat = -1;
    endtask

    task automatic no_done(input string name, input int cycles);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge Clock);
            #1;
            if (Done) seen = 1'b1;
        end
        check(name, {31'b0, seen}, 32'd0);
    endtask

    initial begin
        int lat;
        logic [31:0] prev;
        nReset = 1'b0;
        Start = 1'b0;
        Op = SLL;
        DataA = '0;
        ShiftAmount = '0;
        Flush = 1'b0;

        vecs[0]  = '{SLL, 32'h00000001, 5'd5,  32'h00000020};
        vecs[1]  = '{SRA, 32'h80000000, 5'd31, 32'hFFFFFFFF};
        vecs[2]  = '{SRL, 32'h80000000, 5'd31, 32'h00000001};
        vecs[3]  = '{SRL, 32'h80000000, 5'd0,  32'h80000000};
        vecs[4]  = '{ROR, 32'h00000001, 5'd1,  32'h80000000};
        vecs[5]  = '{SLL, 32'hA5A5A5A5, 5'd4,  32'h5A5A5A50};
        vecs[6]  = '{SRA, 32'h70000000, 5'd7,  32'h00E00000};
        vecs[7]  = '{ROR, 32'h12345678, 5'd8,  32'h78123456};
        vecs[8]  = '{SRL, 32'hFFFFFFFF, 5'd16, 32'h0000FFFF};
        vecs[9]  = '{SRA, 32'h80000010, 5'd4,  32'hF8000001};
        vecs[10] = '{SLL, 32'hFFFFFFFF, 5'd31, 32'h80000000};
        vecs[11] = '{ROR, 32'h0000000F, 5'd4,  32'hF0000000};

        repeat (2) @(posedge Clock);
        #1;
        check("rst_ready", {31'b0, Ready}, 32'd1);
        check("rst_done", {31'b0, Done}, 32'd0);
        check("rst_result", Result, 32'h0);
        nReset = 1'b1;
        @(posedge Clock);
        #1;

        for (int i = 0; i < 12; i++) begin
            accept(vecs[i].op, vecs[i].a, vecs[i].amt);
            wait_done(lat);
            check($sformatf("vec%0d_result", i), Result, vecs[i].res);
            check($sformatf("vec%0d_latency", i), lat,
                  exp_lat(vecs[i].amt));
            check($sformatf("vec%0d_ready", i), {31'b0, Ready}, 32'd1);
            @(posedge Clock);
            #1;
            check($sformatf("vec%0d_pulse", i), {31'b0, Done}, 32'd0);
        end

        // Back-to-back: second request issued in the DONE cycle.
        accept(SRL, 32'h80000000, 5'd0);
        wait_done(lat);
        check("b2b_first_result", Result, 32'h80000000);
        check("b2b_first_lat", lat, 1);
        accept(ROR, 32'h00000001, 5'd1);
        check("b2b_busy", {31'b0, Ready}, 32'd0);
        wait_done(lat);
        check("b2b_second_result", Result, 32'h80000000);
        check("b2b_second_lat", lat, exp_lat(5'd1));

        // Start while busy must be ignored.
        @(posedge Clock);
        #1;
        accept(SLL, 32'h00000003, 5'd6);
        fork
            wait_done(lat);
            begin
                @(posedge Clock);
                #1;
                Start = 1'b1;
                Op = SRL;
                DataA = 32'hDEADBEEF;
                ShiftAmount = 5'd1;
                @(posedge Clock);
                #1;
                check("ign_busy", {31'b0, Ready}, 32'd0);
                @(posedge Clock);
                #1;
                Start = 1'b0;
            end
        join
        check("ign_result", Result, 32'h000000C0);
        check("ign_lat", lat, exp_lat(5'd6));
        prev = Result;

        // Flush during the third busy cycle.
        @(posedge Clock);
        #1;
        accept(SLL, 32'h00000001, 5'd10);
        @(posedge Clock);
        #1;
        @(posedge Clock);
        #1;
        Flush = 1'b1;
        @(posedge Clock);
        #1;
        Flush = 1'b0;
        check("flush_ready", {31'b0, Ready}, 32'd1);
        check("flush_done", {31'b0, Done}, 32'd0);
        check("flush_result", Result, prev);
        no_done("flush_no_done", 20);
        check("flush_hold", Result, prev);
        accept(SLL, 32'h00000001, 5'd10);
        wait_done(lat);
        check("post_flush_result", Result, 32'h00000400);
        check("post_flush_lat", lat, exp_lat(5'd10));

        // Flush and Start together in DONE: request rejected.
        Flush = 1'b1;
        Start = 1'b1;
        DataA = 32'h12345678;
        ShiftAmount = 5'd3;
        @(posedge Clock);
        #1;
        Flush = 1'b0;
        Start = 1'b0;
        check("flush_start_ready", {31'b0, Ready}, 32'd1);
        no_done("flush_start_no_done", 10);
        check("flush_start_result", Result, 32'h00000400);

        // Reset mid-operation.
        accept(SRA, 32'h80000000, 5'd20);
        repeat (2) @(posedge Clock);
        #1;
        nReset = 1'b0;
        @(posedge Clock);
        #1;
        nReset = 1'b1;
        check("mid_rst_ready", {31'b0, Ready}, 32'd1);
        check("mid_rst_done", {31'b0, Done}, 32'd0);
        check("mid_rst_result", Result, 32'h0);
        no_done("mid_rst_no_done", 30);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
